// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the cpu_sequencer control FSM.
// Optional performance counters in the top are enabled by defining
// CPU_SEQ_PERF_COUNTERS_EN.
package cpu_sequencer_pkg;

  // Sequencer states; IDLE must stay the all-zero encoding (reset value).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    DUMP   = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } seq_state;

  // Register-file writeback source select.
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  // PC update source select.
  localparam logic PC_SEQ = 1'b0;
  localparam logic PC_JMP = 1'b1;

  // States in which the sequencer waits on a memory handshake.
  function automatic logic is_wait_state(input seq_state s);
    return (s == FETCH) || (s == MEM);
  endfunction

  // States in which the core is considered running (counted as active cycles).
  function automatic logic is_active_state(input seq_state s);
    return !((s == IDLE) || (s == HALT) || (s == FAULT));
  endfunction

endpackage

// File: rtl/cpu_sequencer_seq_watchdog.sv
// Memory-wait watchdog for the sequencer.
// Counts consecutive wait cycles without an ack. 'expired' is raised
// combinationally during the TIMEOUT_CYCLES-th wait cycle when that cycle
// also has no ack, so the caller can move to FAULT on the next edge while an
// ack arriving on that same last cycle is still honoured.
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst, clear, count_en};
      assign expired   = 1'b0;
    end else begin : g_on
      // Number of completed wait cycles; the current cycle is the last one
      // allowed when this equals TIMEOUT_CYCLES-1.
      localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

      logic [W-1:0] count;

      // Wait-cycle counter: cleared outside a wait, advanced on each ack-less wait cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (count_en && (count != LAST)) begin
          count <= count + 1'b1;
        end
      end

      assign expired = count_en && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH,
// with debug-dump, halt and a memory-wait watchdog that faults the core.
// Strobes are decoded combinationally from the current state and the
// handshake/decoder inputs, so an asynchronous reset drops every request and
// strobe immediately.
// Optional feature: define CPU_SEQ_PERF_COUNTERS_EN to build the cycle and
// retired-instruction counters; otherwise both count ports are tied to 0.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  // instruction memory handshake
  output logic             imemReq,
  input  logic             imemAck,
  output logic             irWE,
  // decoder control
  input  logic             jmpEn,
  input  logic             lsEn,
  input  logic             isStore,
  input  logic             aluWE,
  input  logic             xHalt,
  input  logic             xDebugDump,
  input  logic             branchTaken,
  // data memory handshake
  output logic             dmemReq,
  output logic             dmemWe,
  input  logic             dmemAck,
  // datapath strobes
  output logic             rfWE,
  output logic             rfWbSel,
  output logic             pcWE,
  output logic             pcSel,
  output logic             dumpStrobe,
  // status
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] instretCount
);

  seq_state state;
  seq_state state_next;

  logic waiting;
  logic ack;
  logic wd_expired;

  // A handshake ack only counts in the state that issued the request.
  assign waiting = is_wait_state(state);
  assign ack     = ((state == FETCH) && imemAck) || ((state == MEM) && dmemAck);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (!waiting || ack),
    .count_en (waiting && !ack),
    .expired  (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode; every output defaults to inactive.
  always_comb begin
    state_next = state;
    imemReq    = 1'b0;
    irWE       = 1'b0;
    dmemReq    = 1'b0;
    dmemWe     = 1'b0;
    rfWE       = 1'b0;
    rfWbSel    = WB_ALU;
    pcWE       = 1'b0;
    pcSel      = PC_SEQ;
    dumpStrobe = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          irWE       = 1'b1;
          state_next = DECODE;
        end else if (wd_expired) begin
          state_next = FAULT;
        end
      end

      DECODE: begin
        // Halt outranks a debug dump encoded in the same instruction.
        if (xHalt) begin
          state_next = HALT;
        end else if (xDebugDump) begin
          state_next = DUMP;
        end else begin
          state_next = EXEC;
        end
      end

      EXEC: begin
        if (jmpEn) begin
          pcWE       = 1'b1;
          pcSel      = branchTaken ? PC_JMP : PC_SEQ;
          state_next = FETCH;
        end else if (lsEn) begin
          state_next = MEM;
        end else if (aluWE) begin
          rfWE       = 1'b1;
          rfWbSel    = WB_ALU;
          pcWE       = 1'b1;
          pcSel      = PC_SEQ;
          state_next = FETCH;
        end else begin
          pcWE       = 1'b1;
          pcSel      = PC_SEQ;
          state_next = FETCH;
        end
      end

      MEM: begin
        dmemReq = 1'b1;
        dmemWe  = isStore;
        if (dmemAck) begin
          pcWE  = 1'b1;
          pcSel = PC_SEQ;
          if (!isStore) begin
            rfWE    = 1'b1;
            rfWbSel = WB_MEM;
          end
          state_next = FETCH;
        end else if (wd_expired) begin
          state_next = FAULT;
        end
      end

      DUMP: begin
        dumpStrobe = 1'b1;
        pcWE       = 1'b1;
        pcSel      = PC_SEQ;
        state_next = FETCH;
      end

      HALT: begin
        halted = 1'b1;
      end

      FAULT: begin
        fault  = 1'b1;
        halted = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef CPU_SEQ_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  // Performance counters: running cycles and retired instructions, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (is_active_state(state)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (pcWE) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end

  assign cycleCount   = cycle_cnt;
  assign instretCount = instret_cnt;
`else
  assign cycleCount   = '0;
  assign instretCount = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer (built with TIMEOUT_CYCLES = 4).
// Stimulus is written one instruction at a time; each instruction task derives
// the expected per-cycle strobe pattern from the instruction's class and its
// memory wait counts, queues it, and a single compare process checks the DUT
// against that queue on every falling clock edge.
module tb_cpu_sequencer;

  localparam int unsigned TO    = 4;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic imemReq, imemAck, irWE;
  logic jmpEn, lsEn, isStore, aluWE, xHalt, xDebugDump, branchTaken;
  logic dmemReq, dmemWe, dmemAck;
  logic rfWE, rfWbSel, pcWE, pcSel, dumpStrobe, halted, fault;
  logic [CNT_W-1:0] cycleCount, instretCount;

  cpu_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imemReq     (imemReq),
    .imemAck     (imemAck),
    .irWE        (irWE),
    .jmpEn       (jmpEn),
    .lsEn        (lsEn),
    .isStore     (isStore),
    .aluWE       (aluWE),
    .xHalt       (xHalt),
    .xDebugDump  (xDebugDump),
    .branchTaken (branchTaken),
    .dmemReq     (dmemReq),
    .dmemWe      (dmemWe),
    .dmemAck     (dmemAck),
    .rfWE        (rfWE),
    .rfWbSel     (rfWbSel),
    .pcWE        (pcWE),
    .pcSel       (pcSel),
    .dumpStrobe  (dumpStrobe),
    .halted      (halted),
    .fault       (fault),
    .cycleCount  (cycleCount),
    .instretCount(instretCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic imem_req;
    logic ir_we;
    logic dmem_req;
    logic dmem_we;
    logic rf_we;
    logic rf_wb_sel;
    logic pc_we;
    logic pc_sel;
    logic dump;
    logic halted;
    logic fault;
  } outs_t;

  typedef struct {
    outs_t            o;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ret;
  } exp_t;

  typedef enum {K_NOP, K_ALU, K_JMP, K_LOAD, K_STORE, K_DUMP, K_HALT} kind_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of the architectural counters: cycles spent running, instructions retired.
  logic [CNT_W-1:0] m_cyc = '0;
  logic [CNT_W-1:0] m_ret = '0;

  // Pulse totals observed on the DUT, compared against hand counts at the end.
  int pcwe_seen = 0;
  int rfwe_seen = 0;
  int irwe_seen = 0;
  int dump_seen = 0;

  exp_t  cur;
  outs_t act;

  // Compare process: every queued cycle is checked at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = {imemReq, irWE, dmemReq, dmemWe, rfWE, rfWbSel, pcWE, pcSel,
             dumpStrobe, halted, fault};
      pcwe_seen += int'(pcWE);
      rfwe_seen += int'(rfWE);
      irwe_seen += int'(irWE);
      dump_seen += int'(dumpStrobe);
      checks++;
      if (act !== cur.o) begin
        errors++;
        $display("FAIL strobes @%0t: got %b required %b (imemReq irWE dmemReq dmemWe rfWE rfWbSel pcWE pcSel dump halted fault)",
                 $time, act, cur.o);
      end
      checks++;
`ifdef CPU_SEQ_PERF_COUNTERS_EN
      if (cycleCount !== cur.cyc || instretCount !== cur.ret) begin
`else
      if (cycleCount !== '0 || instretCount !== '0) begin
`endif
        errors++;
        $display("FAIL counters @%0t: got cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                 $time, cycleCount, instretCount, cur.cyc, cur.ret);
      end
    end
  end

  // Queue one cycle's expectation, advance the counter model, move to the next cycle.
  task automatic step(input outs_t e, input bit active);
    exp_t x;
    x.o   = e;
    x.cyc = m_cyc;
    x.ret = m_ret;
    exp_q.push_back(x);
    if (active) m_cyc = m_cyc + 1;
    if (e.pc_we) m_ret = m_ret + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imemAck = 0; dmemAck = 0; jmpEn = 0; lsEn = 0; isStore = 0;
    aluWE = 0; xHalt = 0; xDebugDump = 0; branchTaken = 0;
  endtask

  // Reset for two cycles (asserted mid-cycle), then one IDLE cycle after release.
  task automatic do_reset();
    outs_t z;
    z = '0;
    rst = 1;
    clear_inputs();
    m_cyc = '0;
    m_ret = '0;
    $display("reset");
    step(z, 0);
    step(z, 0);
    rst = 0;
  endtask

  task automatic idle_cycle();
    outs_t z;
    z = '0;
    step(z, 0);
  endtask

  // One instruction. dwait < 0 means the data memory never acks.
  task automatic instr(input kind_t k, input int iwait, input int dwait,
                       input bit taken, input bit hold_iack);
    outs_t e;
    $display("instr %s iwait=%0d dwait=%0d taken=%0d", k.name(), iwait, dwait, taken);
    jmpEn       = (k == K_JMP);
    lsEn        = (k == K_LOAD) || (k == K_STORE);
    isStore     = (k == K_STORE);
    aluWE       = (k == K_ALU) || (k == K_JMP) || (k == K_LOAD);
    xHalt       = (k == K_HALT);
    xDebugDump  = (k == K_DUMP) || (k == K_HALT);
    branchTaken = taken;
    dmemAck     = 0;
    // fetch: request every cycle, IR load on the ack cycle
    for (int i = 0; i <= iwait; i++) begin
      e = '0;
      e.imem_req = 1;
      e.ir_we    = (i == iwait);
      imemAck    = hold_iack || (i == iwait);
      step(e, 1);
    end
    imemAck = hold_iack;
    // decode: silent
    e = '0;
    step(e, 1);
    if (k == K_HALT) begin
      imemAck = 1;
      dmemAck = 1;
      for (int i = 0; i < 3; i++) begin
        e = '0;
        e.halted = 1;
        step(e, 0);
      end
    end else if (k == K_DUMP) begin
      e = '0;
      e.dump  = 1;
      e.pc_we = 1;
      step(e, 1);
    end else if (k == K_LOAD || k == K_STORE) begin
      e = '0;
      step(e, 1);
      for (int i = 0; (dwait < 0) ? (i < int'(TO)) : (i <= dwait); i++) begin
        e = '0;
        e.dmem_req = 1;
        e.dmem_we  = (k == K_STORE);
        if (i == dwait) begin
          dmemAck     = 1;
          e.pc_we     = 1;
          e.rf_we     = (k == K_LOAD);
          e.rf_wb_sel = (k == K_LOAD);
        end
        step(e, 1);
      end
      dmemAck = 0;
      if (dwait < 0) begin
        // watchdog fault: terminal, late acks ignored
        dmemAck = 1;
        imemAck = 1;
        for (int i = 0; i < 3; i++) begin
          e = '0;
          e.fault  = 1;
          e.halted = 1;
          step(e, 0);
        end
      end
    end else begin
      e = '0;
      e.pc_we  = 1;
      e.pc_sel = (k == K_JMP) && taken;
      e.rf_we  = (k == K_ALU);
      step(e, 1);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  initial begin
    outs_t e;
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();
    imemAck = 1;                     // ack held high from reset release
    idle_cycle();
    instr(K_NOP, 0, 0, 0, 1);
`ifdef CPU_SEQ_PERF_COUNTERS_EN
    check_lit("instret_after_nop", int'(instretCount), 1);
    check_lit("cycles_after_nop", int'(cycleCount), 3);
`endif
    instr(K_ALU,   3, 0, 0, 0);      // ack on the last allowed fetch wait cycle
    instr(K_JMP,   0, 0, 1, 0);
    instr(K_JMP,   0, 0, 0, 0);
    instr(K_LOAD,  0, 2, 0, 0);
    instr(K_STORE, 0, 2, 0, 0);
    instr(K_DUMP,  0, 0, 0, 0);
    instr(K_LOAD,  0, 3, 0, 0);      // ack on the last allowed data wait cycle
`ifdef CPU_SEQ_PERF_COUNTERS_EN
    check_lit("instret_before_fault", int'(instretCount), 8);
`endif
    instr(K_LOAD,  0, -1, 0, 0);     // data memory never acks
    do_reset();
    idle_cycle();
    instr(K_HALT,  0, 0, 0, 0);      // xHalt and xDebugDump together
    do_reset();
    idle_cycle();
    // load interrupted by reset while waiting in MEM
    $display("instr LOAD interrupted by reset");
    lsEn = 1; aluWE = 1;
    imemAck = 1;
    e = '0; e.imem_req = 1; e.ir_we = 1;
    step(e, 1);
    imemAck = 0;
    e = '0;
    step(e, 1);
    step(e, 1);
    e = '0; e.dmem_req = 1;
    step(e, 1);
    do_reset();
    idle_cycle();
    instr(K_NOP, 1, 0, 0, 0);
`ifdef CPU_SEQ_PERF_COUNTERS_EN
    check_lit("instret_final", int'(instretCount), 1);
`endif
    check_lit("pcWE_pulses", pcwe_seen, 9);
    check_lit("rfWE_pulses", rfwe_seen, 3);
    check_lit("irWE_pulses", irwe_seen, 12);
    check_lit("dump_pulses", dump_seen, 1);
    check_lit("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

endmodule
